// File: rtl/axis_in_pack.sv
// rtl/axis_in_pack.sv - column-gathering AXI-Stream receiver
// Packs COLS narrow beats into one wide word; an early s_last zero-pads the lower columns.
module axis_in_pack #(
  parameter int ROWS       = 2,
  parameter int COLS       = 4,
  parameter int WORD_WIDTH = 8,
  localparam int CW        = $clog2(COLS + 1)
) (
  input  logic                                        aclk,
  input  logic                                        aresetn,
  input  logic                                        s_valid,
  output logic                                        s_ready,
  input  logic [ROWS-1:0][WORD_WIDTH-1:0]             s_data,
  input  logic                                        s_last,
  input  logic                                        m_ready,
  output logic                                        m_valid,
  output logic [COLS-1:0][ROWS-1:0][WORD_WIDTH-1:0]   m_data,
  output logic [COLS-1:0]                             m_keep,
  output logic                                        m_last,
  output logic [CW-1:0]                               m_cols
);

  typedef enum logic [1:0] {FILL, PAD, OUT} state_t;

  localparam logic [CW-1:0] COLS_C = CW'(COLS);

  state_t                                     state_q, state_d;
  logic [CW-1:0]                              count_q, count_d;
  logic                                       s_ready_q, s_ready_d;
  logic                                       m_valid_q, m_valid_d;
  logic                                       m_last_q, m_last_d;
  logic [COLS-1:0][ROWS-1:0][WORD_WIDTH-1:0]  m_data_q, m_data_d;
  logic [COLS-1:0]                            m_keep_q, m_keep_d;
  logic [CW-1:0]                              m_cols_q, m_cols_d;
  logic [CW-1:0]                              count_inc;

  assign count_inc = count_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    s_ready_d = s_ready_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_cols_d  = m_cols_q;
    case (state_q)
      FILL: begin
        if (s_valid) begin
          // Shift left so the first beat of the word ends up in column COLS-1.
          m_data_d = {m_data_q[COLS-2:0], s_data};
          m_keep_d = {m_keep_q[COLS-2:0], 1'b1};
          count_d  = count_inc;
          m_cols_d = count_inc;
          if (count_inc == COLS_C) begin
            state_d   = OUT;
            s_ready_d = 1'b0;
            m_valid_d = 1'b1;
            m_last_d  = s_last;
          end else if (s_last) begin
            state_d   = PAD;
            s_ready_d = 1'b0;
            m_last_d  = 1'b1;
          end
        end
      end
      PAD: begin
        m_data_d = {m_data_q[COLS-2:0], {(ROWS*WORD_WIDTH){1'b0}}};
        m_keep_d = {m_keep_q[COLS-2:0], 1'b0};
        count_d  = count_inc;
        if (count_inc == COLS_C) begin
          state_d   = OUT;
          m_valid_d = 1'b1;
        end
      end
      OUT: begin
        if (m_ready) begin
          state_d   = FILL;
          s_ready_d = 1'b1;
          m_valid_d = 1'b0;
          count_d   = '0;
          m_keep_d  = '0;
          m_last_d  = 1'b0;
        end
      end
      default: begin
        state_d   = FILL;
        s_ready_d = 1'b1;
        m_valid_d = 1'b0;
        count_d   = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= FILL;
      count_q   <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_cols_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_cols_q  <= m_cols_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_cols  = m_cols_q;

endmodule

// File: tb/tb_axis_in_pack.sv
// tb/tb_axis_in_pack.sv - self-checking bench for axis_in_pack
// Packet vectors from a table, then reset, backpressure and random-handshake sequences.
module tb_axis_in_pack;
  localparam int ROWS = 2;
  localparam int COLS = 4;
  localparam int W    = 8;
  localparam int CW   = $clog2(COLS + 1);

  logic                          aclk = 1'b0;
  logic                          aresetn;
  logic                          s_valid;
  logic                          s_ready;
  logic [ROWS-1:0][W-1:0]        s_data;
  logic                          s_last;
  logic                          m_ready;
  logic                          m_valid;
  logic [COLS-1:0][ROWS-1:0][W-1:0] m_data;
  logic [COLS-1:0]               m_keep;
  logic                          m_last;
  logic [CW-1:0]                 m_cols;

  int tests = 0;
  int fails = 0;

  axis_in_pack #(.ROWS(ROWS), .COLS(COLS), .WORD_WIDTH(W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_ready(m_ready), .m_valid(m_valid), .m_data(m_data),
    .m_keep(m_keep), .m_last(m_last), .m_cols(m_cols)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int          nb;
    logic [31:0] beats;
    logic        last;
    logic [63:0] exp_data;
    logic [3:0]  exp_keep;
    logic [2:0]  exp_cols;
    logic        exp_last;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] beat_of(input logic [7:0] b);
    return {b, ~b};
  endfunction

  task automatic send_beat(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = beat_of(b);
    s_last  = last;
    while (!s_ready && n < 50) begin
      step();
      n++;
    end
    if (!s_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: s_ready stuck low for beat %h", b);
    end
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // s_ready and m_valid must never be high in the same cycle.
  always @(negedge aclk) begin
    if (aresetn === 1'b1) begin
      tests++;
      if (s_ready && m_valid) begin
        fails++;
        $display("FAIL ready_valid_overlap: s_ready=%b m_valid=%b", s_ready, m_valid);
      end
    end
  end

  initial begin
    int lat;
    logic [63:0] held_data;
    logic [3:0]  held_keep;
    logic [2:0]  held_cols;
    logic        held_last;

    vecs[0] = '{4, 32'h11223344, 1'b1, 64'h11EE_22DD_33CC_44BB, 4'b1111, 3'd4, 1'b1, 1};
    vecs[1] = '{2, 32'hAABB0000, 1'b1, 64'hAA55_BB44_0000_0000, 4'b1100, 3'd2, 1'b1, 3};
    vecs[2] = '{1, 32'h5A000000, 1'b1, 64'h5AA5_0000_0000_0000, 4'b1000, 3'd1, 1'b1, 4};
    vecs[3] = '{3, 32'h01020300, 1'b1, 64'h01FE_02FD_03FC_0000, 4'b1110, 3'd3, 1'b1, 2};
    vecs[4] = '{4, 32'h10203040, 1'b0, 64'h10EF_20DF_30CF_40BF, 4'b1111, 3'd4, 1'b0, 1};

    aresetn = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    #12;
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_last",  64'(m_last),  64'd0);
    check("rst_m_data",  64'(m_data),  64'd0);
    check("rst_m_keep",  64'(m_keep),  64'd0);
    check("rst_m_cols",  64'(m_cols),  64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    step();

    // Reset mid-FILL after two beats discards the partial word.
    send_beat(8'h77, 1'b0);
    send_beat(8'h88, 1'b0);
    #2;
    aresetn = 1'b0;
    #1;
    check("midrst_s_ready", 64'(s_ready), 64'd1);
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    check("midrst_m_keep",  64'(m_keep),  64'd0);
    check("midrst_m_cols",  64'(m_cols),  64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    step();

    // Table vectors; m_ready held high throughout, including outside OUT.
    for (int i = 0; i < 5; i++) begin
      m_ready = 1'b1;
      for (int j = 0; j < vecs[i].nb; j++)
        send_beat(vecs[i].beats[31-8*j -: 8], vecs[i].last && (j == vecs[i].nb - 1));
      lat = 1;
      while (!m_valid && lat < 20) begin
        step();
        lat++;
      end
      check($sformatf("v%0d_latency", i), 64'(lat),      64'(vecs[i].exp_lat));
      check($sformatf("v%0d_m_data", i),  64'(m_data),   vecs[i].exp_data);
      check($sformatf("v%0d_m_keep", i),  64'(m_keep),   64'(vecs[i].exp_keep));
      check($sformatf("v%0d_m_cols", i),  64'(m_cols),   64'(vecs[i].exp_cols));
      check($sformatf("v%0d_m_last", i),  64'(m_last),   64'(vecs[i].exp_last));
      check($sformatf("v%0d_s_ready", i), 64'(s_ready),  64'd0);
      step();
      check($sformatf("v%0d_post_valid", i), 64'(m_valid), 64'd0);
      check($sformatf("v%0d_post_ready", i), 64'(s_ready), 64'd1);
      m_ready = 1'b0;
    end

    // Backpressure: hold m_ready low for 10 cycles in OUT while s_valid is asserted.
    m_ready = 1'b0;
    send_beat(8'hC1, 1'b0);
    send_beat(8'hC2, 1'b0);
    send_beat(8'hC3, 1'b0);
    send_beat(8'hC4, 1'b1);
    check("bp_valid", 64'(m_valid), 64'd1);
    check("bp_data",  64'(m_data),  64'hC13E_C23D_C33C_C43B);
    held_data = m_data;
    held_keep = m_keep;
    held_cols = m_cols;
    held_last = m_last;
    s_valid = 1'b1;
    s_data  = beat_of(8'hEE);
    s_last  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("bp_hold_data", 64'(m_data), held_data);
      check("bp_hold_ctrl", 64'({m_valid, s_ready, m_last, m_cols, m_keep}),
            64'({1'b1, 1'b0, held_last, held_cols, held_keep}));
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    step();
    check("bp_release_valid", 64'(m_valid), 64'd0);
    check("bp_release_ready", 64'(s_ready), 64'd1);
    m_ready = 1'b0;
    step();

    // Random handshakes, three 8-beat packets -> six words, m_last on odd words.
    fork
      begin : driver
        int guard;
        logic acc;
        guard = 0;
        for (int p = 0; p < 3; p++) begin
          for (int j = 0; j < 8; j++) begin
            s_data = beat_of(8'(8'h10 * (p + 1) + j));
            s_last = (j == 7);
            acc = 1'b0;
            while (!acc && guard < 3000) begin
              s_valid = ($urandom_range(0, 3) != 0);
              acc = s_valid && s_ready;
              step();
              guard++;
            end
          end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (guard >= 3000) begin
          tests++;
          fails++;
          $display("FAIL rnd_driver_timeout: guard=%0d limit=3000", guard);
        end
      end
      begin : monitor
        int words;
        int guard;
        logic [63:0] exp;
        words = 0;
        guard = 0;
        while (words < 6 && guard < 4000) begin
          m_ready = ($urandom_range(0, 1) != 0);
          if (m_valid && m_ready) begin
            for (int c = 0; c < 4; c++)
              exp[(3-c)*16 +: 16] = beat_of(8'(8'h10 * (words / 2 + 1) + (words % 2) * 4 + c));
            check($sformatf("rnd_w%0d_data", words), 64'(m_data), exp);
            check($sformatf("rnd_w%0d_keep_cols", words), 64'({m_keep, m_cols}), 64'({4'b1111, 3'd4}));
            check($sformatf("rnd_w%0d_last", words), 64'(m_last), 64'(words % 2));
            words++;
          end
          step();
          guard++;
        end
        m_ready = 1'b0;
        check("rnd_word_count", 64'(words), 64'd6);
      end
    join

    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check("rnd_no_extra_word", 64'(m_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
